// File: rtl/edge_detector_multi.sv
// N-channel input conditioner: synchroniser, glitch filter, registered edge pulses,
// plus a mode-qualified event that feeds a sticky flag and a saturating counter.
module edge_detector_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       clr,
    output logic [N-1:0]       positive_edge,
    output logic [N-1:0]       negative_edge,
    output logic [N-1:0]       event_pulse,
    output logic [N-1:0]       sticky,
    output logic [N*CNT_W-1:0] count
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FILTER - 1);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync;
            logic                   sync_out;
            logic                   level;
            logic [FW-1:0]          fcnt;
            logic                   accept;
            logic                   rise;
            logic                   fall;
            logic                   evt;
            logic                   pe_q;
            logic                   ne_q;
            logic                   ev_q;
            logic                   sticky_q;
            logic [CNT_W-1:0]       cnt_q;

            assign sync_out = sync[SYNC_STAGES-1];

            always_comb begin
                accept = (sync_out != level) && (fcnt == F_LAST);
                rise   = accept & sync_out;
                fall   = accept & ~sync_out;
                evt    = (rise & mode[0]) | (fall & mode[1]);
            end

            // sticky/count react to the same event that loads ev_q, so they
            // change in the cycle event_pulse is high; clr loses to a coincident event.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync     <= '0;
                    level    <= 1'b0;
                    fcnt     <= '0;
                    pe_q     <= 1'b0;
                    ne_q     <= 1'b0;
                    ev_q     <= 1'b0;
                    sticky_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync <= {sync[SYNC_STAGES-2:0], in[i]};
                    pe_q <= rise;
                    ne_q <= fall;
                    ev_q <= evt;
                    if (sync_out == level) begin
                        fcnt <= '0;
                    end else if (accept) begin
                        level <= sync_out;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                    if (evt) begin
                        sticky_q <= 1'b1;
                    end else if (clr[i]) begin
                        sticky_q <= 1'b0;
                    end
                    if (clr[i]) begin
                        cnt_q <= evt ? CNT_W'(1) : '0;
                    end else if (evt && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign positive_edge[i]          = pe_q;
            assign negative_edge[i]          = ne_q;
            assign event_pulse[i]            = ev_q;
            assign sticky[i]                 = sticky_q;
            assign count[i*CNT_W +: CNT_W]   = cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi (N=4, SYNC_STAGES=2, FILTER=3, CNT_W=2).
module tb_edge_detector_multi;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic               clk;
    logic               rst;
    logic [N-1:0]       in;
    logic [1:0]         mode;
    logic [N-1:0]       clr;
    logic [N-1:0]       positive_edge;
    logic [N-1:0]       negative_edge;
    logic [N-1:0]       event_pulse;
    logic [N-1:0]       sticky;
    logic [N*CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;
    int pe_n[N];
    int ne_n[N];
    int ev_n[N];
    int both_n;

    edge_detector_multi #(.N(N), .SYNC_STAGES(2), .FILTER(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in(in), .mode(mode), .clr(clr),
        .positive_edge(positive_edge), .negative_edge(negative_edge),
        .event_pulse(event_pulse), .sticky(sticky), .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_counts();
        for (int k = 0; k < N; k++) begin
            pe_n[k] = 0;
            ne_n[k] = 0;
            ev_n[k] = 0;
        end
        both_n = 0;
    endtask

    task automatic run_count(input int n);
        for (int s = 0; s < n; s++) begin
            step();
            for (int k = 0; k < N; k++) begin
                pe_n[k] += int'(positive_edge[k]);
                ne_n[k] += int'(negative_edge[k]);
                ev_n[k] += int'(event_pulse[k]);
                if (positive_edge[k] && negative_edge[k]) both_n++;
            end
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return count[ch*CNT_W +: CNT_W];
    endfunction

    initial begin
        rst  = 1'b0;
        in   = '0;
        mode = 2'b00;
        clr  = '0;
        zero_counts();

        // reset state
        step();
        step();
        chk("rst_pe", 32'(positive_edge), 0);
        chk("rst_ne", 32'(negative_edge), 0);
        chk("rst_ev", 32'(event_pulse), 0);
        chk("rst_sticky", 32'(sticky), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b1;
        step();
        step();

        // latency: in[0] rises, pulse between edges 4 and 5
        in[0] = 1'b1;
        step();                     // edge 0
        chk("lat_e0", 32'(positive_edge), 0);
        step(); step(); step();     // edges 1..3
        chk("lat_e3", 32'(positive_edge), 0);
        step();                     // edge 4
        chk("lat_e4_pe", 32'(positive_edge), 32'b0001);
        chk("lat_e4_ne", 32'(negative_edge), 0);
        chk("lat_e4_ev_mode00", 32'(event_pulse), 0);
        step();                     // edge 5
        chk("lat_e5_pe", 32'(positive_edge), 0);
        chk("lat_sticky_mode00", 32'(sticky), 0);

        // 2-cycle glitch on in[1]
        zero_counts();
        in[1] = 1'b1;
        step();
        step();
        in[1] = 1'b0;
        run_count(10);
        chk("glitch_pe1", 32'(pe_n[1]), 0);
        chk("glitch_ne1", 32'(ne_n[1]), 0);
        chk("glitch_count1", 32'(cnt_of(1)), 0);

        // mode=01 on channel 2: one rise, one fall
        mode = 2'b01;
        zero_counts();
        in[2] = 1'b1;
        run_count(10);
        in[2] = 1'b0;
        run_count(10);
        chk("m01_pe2", 32'(pe_n[2]), 1);
        chk("m01_ne2", 32'(ne_n[2]), 1);
        chk("m01_ev2", 32'(ev_n[2]), 1);
        chk("m01_sticky2", 32'(sticky[2]), 1);
        chk("m01_count2", 32'(cnt_of(2)), 1);

        // mode=11: both edges count, 1 -> 3
        mode = 2'b11;
        zero_counts();
        in[2] = 1'b1;
        run_count(10);
        in[2] = 1'b0;
        run_count(10);
        chk("m11_ev2", 32'(ev_n[2]), 2);
        chk("m11_count2", 32'(cnt_of(2)), 3);
        chk("m11_both", 32'(both_n), 0);

        // saturation on channel 3
        zero_counts();
        for (int t = 0; t < 5; t++) begin
            in[3] = ~in[3];
            run_count(10);
        end
        chk("sat_ev3", 32'(ev_n[3]), 5);
        chk("sat_count3", 32'(cnt_of(3)), 3);
        chk("sat_sticky3", 32'(sticky[3]), 1);
        clr[3] = 1'b1;
        step();
        clr[3] = 1'b0;
        chk("clr_count3", 32'(cnt_of(3)), 0);
        chk("clr_sticky3", 32'(sticky[3]), 0);

        // clr coincident with an event
        in[3] = 1'b0;
        step(); step(); step(); step();   // edges 0..3
        clr[3] = 1'b1;
        step();                           // edge 4: event + clr
        clr[3] = 1'b0;
        chk("clrev_ne3", 32'(negative_edge[3]), 1);
        chk("clrev_ev3", 32'(event_pulse[3]), 1);
        chk("clrev_count3", 32'(cnt_of(3)), 1);
        chk("clrev_sticky3", 32'(sticky[3]), 1);
        step();
        chk("clrev_ne3_once", 32'(negative_edge[3]), 0);

        // all channels toggle together
        clr = '1;
        step();
        clr = '0;
        chk("clr_all_count", 32'(count), 0);
        in = 4'b1110;
        step(); step(); step(); step();   // edges 0..3
        chk("all_e3_pe", 32'(positive_edge), 0);
        step();                           // edge 4
        chk("all_pe", 32'(positive_edge), 32'b1110);
        chk("all_ne", 32'(negative_edge), 32'b0001);
        chk("all_ev", 32'(event_pulse), 32'b1111);
        chk("all_sticky", 32'(sticky), 32'b1111);
        chk("all_count", 32'(count), 32'b01010101);
        step();
        chk("all_pe_off", 32'(positive_edge | negative_edge), 0);

        // reset during an in-progress filter window
        in = 4'b0001;
        step(); step(); step();           // edges 0..2
        rst = 1'b0;
        step();                           // edge 3
        chk("midrst_pe", 32'(positive_edge), 0);
        chk("midrst_ne", 32'(negative_edge), 0);
        chk("midrst_ev", 32'(event_pulse), 0);
        chk("midrst_sticky", 32'(sticky), 0);
        chk("midrst_count", 32'(count), 0);
        step();                           // edge 4: pulse would have landed here
        chk("midrst_e4_pe", 32'(positive_edge | negative_edge), 0);

        // channel 0 held high through reset release
        rst = 1'b1;
        zero_counts();
        run_count(12);
        chk("hold_pe0", 32'(pe_n[0]), 1);
        chk("hold_ne", 32'(ne_n[0] + ne_n[1] + ne_n[2] + ne_n[3]), 0);
        chk("hold_pe_others", 32'(pe_n[1] + pe_n[2] + pe_n[3]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
